uart_rx_axis_bridge: RTL and testbench
======================================

UART_RX_AXIS_BRIDGE -- requirements
Module: uart_rx_axis_bridge

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434: clk cycles per UART bit (50 MHz / 115200); legal range >= 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: receive buffer entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1: single clock for all logic.
REQ-004 SHALL have port rst  input  1: reset, synchronous to clk and active-high.
REQ-005 SHALL have port rx  input  1: asynchronous UART serial line, idle high.
REQ-006 SHALL have port m_axis_tdata  output  8: received byte.
REQ-007 SHALL have port m_axis_tvalid  output  1: byte available.
REQ-008 SHALL have port m_axis_tready  input  1: downstream accepts.
REQ-009 SHALL have port frame_err  output  1: single-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overflow  output  1: sticky flag set when a byte is dropped because the FIFO is full.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer, preset to 1; all decoding uses the synchronized value.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, with one bit-timing counter and a 3-bit bit index.
REQ-013 SHALL, in IDLE, on synchronized rx = 0: clear the counter and enter START.
REQ-014 SHALL, in START, when the counter reaches CLKS_PER_BIT/2-1: enter DATA if rx = 0, else return to IDLE (glitch rejected, no output).
REQ-015 SHALL, in DATA, sample rx every CLKS_PER_BIT cycles into the shift register, LSB first; after bit 7 enter STOP.
REQ-016 SHALL, in STOP, sample rx after CLKS_PER_BIT cycles.
  - rx = 1: push the byte.
  - rx = 0: pulse frame_err for 1 cycle and discard the byte.
  - Either case: return to IDLE in the same cycle, ready to detect the next start bit.
REQ-017 SHALL assert m_axis_tvalid on the cycle after the push (1-cycle latency from the stop sample), given an empty FIFO.
REQ-018 SHALL present the FIFO head combinationally on m_axis_tdata (first-word fall-through); m_axis_tvalid = FIFO not empty.
REQ-019 SHALL pop exactly one entry per cycle in which m_axis_tvalid && m_axis_tready.
REQ-020 SHALL hold m_axis_tdata and m_axis_tvalid stable while m_axis_tvalid && !m_axis_tready.
REQ-021 SHALL, on push with the FIFO full and no pop that cycle: drop the new byte, keep contents intact, set overflow.
REQ-022 SHALL, on push and pop in the same cycle with the FIFO full: accept both; occupancy unchanged, no overflow.
REQ-023 SHALL wrap read/write pointers modulo FIFO_DEPTH; occupancy uses log2(FIFO_DEPTH)+1 bits.
REQ-024 SHALL NOT signal frame_err on a start-bit glitch.

Reset
REQ-025 SHALL, while rst = 1 at a clk edge, force:
  - FSM to IDLE; counters and shift register to 0; synchronizer flops to 1.
  - FIFO empty; m_axis_tvalid = 0, m_axis_tdata = 0, frame_err = 0, overflow = 0.
REQ-026 SHALL abandon any frame in progress when reset asserts mid-reception; no partial byte is pushed.
REQ-027 SHALL clear overflow only by reset.

Structure
REQ-028 SHALL place the FSM state encoding, the UART frame width (8) and the default CLKS_PER_BIT in the shared UART/AXIS package used by the TX path.
REQ-029 SHALL instantiate the team's existing sync_fifo as its single sub-module for buffering; the receive FSM stays in this module.

Verification (bench uses CLKS_PER_BIT = 16, FIFO_DEPTH = 4)
REQ-030 SHALL cover: send 0xA5 8N1 with tready = 1 -> tvalid high for 1 cycle with tdata = 0xA5, 1 cycle after the stop sample; frame_err = 0.
REQ-031 SHALL cover: 4-cycle low pulse on idle rx -> FSM back to IDLE; no tvalid, no frame_err.
REQ-032 SHALL cover: send 0x3C with stop bit = 0 -> frame_err pulses 1 cycle; tvalid stays 0.
REQ-033 SHALL cover: tready = 0, send 0x01..0x05 -> overflow = 1 after the 5th byte; then tready = 1 -> drains 0x01, 0x02, 0x03, 0x04 in order, tdata stable while stalled.
REQ-034 SHALL cover: FIFO full, tready pulsed in the stop-sample cycle of byte 0x77 -> 0x77 accepted, overflow = 0.
REQ-035 SHALL cover: rst asserted during data bit 4 of 0xFF, released, then 0x12 sent -> only 0x12 appears on the output.

Source files
------------

// File: rtl/uart_rx_axis_bridge_pkg.sv
// Shared UART/AXIS definitions: receive FSM encoding, frame width and default bit timing.
package uart_rx_axis_bridge_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO; a push into a full FIFO succeeds only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_axis_bridge.sv
// UART 8N1 receiver feeding an AXI-Stream master through a small FWFT FIFO.
//   state | meaning
//   IDLE  | line idle, waiting for synchronized rx low
//   START | timing to mid start bit; rx high there is a glitch
//   DATA  | sampling 8 data bits LSB first, one per bit period
//   STOP  | sampling stop bit; push byte or flag framing error
module uart_rx_axis_bridge
  import uart_rx_axis_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  uart_rx_state_t            state;
  logic [CNT_W-1:0]          cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      rx_meta;
  logic                      rx_sync;
  logic                      push;
  logic                      pop;
  logic                      fifo_empty;
  logic                      fifo_full;

  // Push straight from the stop-sample cycle so the byte is visible one cycle later.
  assign push          = (state == STOP) && (cnt == BIT_LAST) && rx_sync;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tvalid = !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      frame_err <= 1'b0;
      if (push && fifo_full && !pop) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[UART_DATA_BITS-1:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt       <= '0;
            frame_err <= !rx_sync;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .pop_data  (m_axis_tdata),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_uart_rx_axis_bridge.sv
// Directed bench for uart_rx_axis_bridge with 16 clocks per bit and a 4-entry FIFO.
module tb_uart_rx_axis_bridge;
  import uart_rx_axis_bridge_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       frame_err;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  uart_rx_axis_bridge #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .frame_err     (frame_err),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, data and stop bits; returns inside the stop-sample cycle.
  task automatic send_to_stop(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(16);
    end
    rx = stop_bit;
    step(10);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_to_stop(d, 1'b1);
    step(1);
    rx = 1'b1;
    step(20);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1; m_axis_tready = 1'b0;
    step(3);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got=%h exp=00", m_axis_tdata); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
    rst = 1'b0;
    step(5);
  endtask

  task automatic test_single_byte;
    m_axis_tready = 1'b1;
    send_to_stop(8'hA5, 1'b1);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL a5_tvalid_early got=%b exp=0", m_axis_tvalid); end
    step(1);
    rx = 1'b1;
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL a5_tvalid got=%b exp=1", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 8'hA5) begin errors++; $display("FAIL a5_tdata got=%h exp=a5", m_axis_tdata); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL a5_frame_err got=%b exp=0", frame_err); end
    step(1);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL a5_tvalid_one_cycle got=%b exp=0", m_axis_tvalid); end
    step(20);
  endtask

  task automatic test_glitch;
    logic seen = 1'b0;
    rx = 1'b0;
    step(4);
    checks++; if (dut.state !== START) begin errors++; $display("FAIL glitch_start got=%0d exp=%0d", dut.state, START); end
    rx = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (m_axis_tvalid !== 1'b0 || frame_err !== 1'b0) seen = 1'b1;
      step(1);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch_output got=%b exp=0", seen); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL glitch_idle got=%0d exp=%0d", dut.state, IDLE); end
  endtask

  task automatic test_frame_error;
    logic seen = 1'b0;
    m_axis_tready = 1'b1;
    send_to_stop(8'h3C, 1'b0);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_early got=%b exp=0", frame_err); end
    step(1);
    rx = 1'b1;
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_pulse got=%b exp=1", frame_err); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ferr_tvalid got=%b exp=0", m_axis_tvalid); end
    step(1);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_width got=%b exp=0", frame_err); end
    for (int i = 0; i < 30; i++) begin
      if (m_axis_tvalid !== 1'b0 || frame_err !== 1'b0) seen = 1'b1;
      step(1);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ferr_after got=%b exp=0", seen); end
  endtask

  task automatic test_overflow;
    logic [7:0] exp;
    m_axis_tready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    checks++; if (m_axis_tdata !== 8'h01) begin errors++; $display("FAIL ovf_head_stall got=%h exp=01", m_axis_tdata); end
    send_byte(8'h03);
    send_byte(8'h04);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow); end
    send_byte(8'h05);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h01) begin
      errors++; $display("FAIL ovf_stall_hold got=%b/%h exp=1/01", m_axis_tvalid, m_axis_tdata);
    end
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i);
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp) begin
        errors++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, m_axis_tvalid, m_axis_tdata, exp);
      end
      step(1);
    end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", m_axis_tvalid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    m_axis_tready = 1'b0;
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp_q [4] = '{8'h20, 8'h30, 8'h40, 8'h77};
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    m_axis_tready = 1'b0;
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h40);
    send_to_stop(8'h77, 1'b1);
    m_axis_tready = 1'b1;
    step(1);
    m_axis_tready = 1'b0;
    rx = 1'b1;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pp_overflow got=%b exp=0", overflow); end
    step(20);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_q[i]) begin
        errors++; $display("FAIL full_pp_drain%0d got=%b/%h exp=1/%h", i, m_axis_tvalid, m_axis_tdata, exp_q[i]);
      end
      step(1);
    end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL full_pp_empty got=%b exp=0", m_axis_tvalid); end
  endtask

  task automatic test_reset_mid_frame;
    logic seen = 1'b0;
    m_axis_tready = 1'b1;
    rx = 1'b0;
    step(16);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      step(16);
    end
    rx = 1'b1;
    step(8);
    rst = 1'b1;
    step(2);
    checks++; if (dut.state !== IDLE || dut.shreg !== 8'h00) begin
      errors++; $display("FAIL mid_rst_state got=%0d/%h exp=%0d/00", dut.state, dut.shreg, IDLE);
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_axis_tvalid !== 1'b0 || frame_err !== 1'b0) seen = 1'b1;
      step(1);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_partial got=%b exp=0", seen); end
    send_to_stop(8'h12, 1'b1);
    step(1);
    rx = 1'b1;
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h12) begin
      errors++; $display("FAIL mid_rst_12 got=%b/%h exp=1/12", m_axis_tvalid, m_axis_tdata);
    end
    step(1);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_only got=%b exp=0", m_axis_tvalid); end
    step(20);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
